// File: rtl/instr_dispatch_fsm.sv
// Instruction fetch/decode/dispatch controller: fetches a 16-bit word at pc and
// hands it to the ALU or move sequencer. A watchdog guards the wait for completion.
module instr_dispatch_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_valid,
    output logic [3:0]  opCode,
    output logic [5:0]  Ri,
    output logic [5:0]  Rj,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        mov_start,
    input  logic        mov_done,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        illegal,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_DISPATCH, S_WAIT, S_INCR, S_HALT, S_ERROR
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [7:0] WDOG_LAST = 8'd254;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        is_mov;
    logic        done_match;

    // Only MOV reaches DISPATCH/WAIT with opcode bit 3 set, so it selects the target.
    assign is_mov     = ir_q[15];
    assign done_match = is_mov ? mov_done : alu_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            wdog_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            wdog_q    <= wdog_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        wdog_d    = wdog_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_valid) begin
                    ir_d    = mem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[15] || ir_q[15:12] == OP_MOV) begin
                    state_d = S_DISPATCH;
                end else if (ir_q[15:12] == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_INCR;
                end
            end
            S_DISPATCH: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final watchdog cycle still wins.
                if (done_match) begin
                    state_d = S_INCR;
                end else if (wdog_q == WDOG_LAST) begin
                    wdog_d    = wdog_q + 8'd1;
                    timeout_d = 1'b1;
                    state_d   = S_ERROR;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            S_INCR: begin
                pc_d    = pc_q + 8'd1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign opCode    = ir_q[15:12];
    assign Ri        = ir_q[11:6];
    assign Rj        = ir_q[5:0];
    assign mem_rd    = (state_q == S_FETCH);
    assign alu_start = (state_q == S_DISPATCH) && !is_mov;
    assign mov_start = (state_q == S_DISPATCH) && is_mov;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule
